// File: rtl/sub_result_stage.sv
// sub_result_stage: registered valid/ready stage behind the combinational DSP subtractor.
// Operands go straight to the subtractor. The difference, its carry and the derived compare
// flags {ltu,lt,v,n,z} are captured into a 2-entry FIFO skid buffer. The buffer head drives
// the consumer-side outputs.
// in_ready is decoded from the registered occupancy only, so there is no combinational path
// from out_ready to in_ready.
// Optional feature: define SUB_RESULT_CHECK_EN to add a fabric subtractor. It cross-checks
// every accepted DSP result and raises a sticky mismatch flag. Without it, mismatch is tied 0.
// WIDTH must be 32 to match the DSP subtractor.
module sub_result_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] sub_input1,
    output logic [WIDTH-1:0] sub_input2,
    input  logic [WIDTH-1:0] sub_out,
    input  logic             sub_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_co,
    output logic [4:0]       out_flags,
    output logic             mismatch
);

    // Buffer occupancy doubles as the control state.
    localparam logic [1:0] CntEmpty = 2'd0;
    localparam logic [1:0] CntOne   = 2'd1;
    localparam logic [1:0] CntFull  = 2'd2;

    logic [1:0]       count_q, count_d;
    logic             rd_ptr_q, wr_ptr_q;
    logic [WIDTH-1:0] diff_q  [2];
    logic             co_q    [2];
    logic [4:0]       flags_q [2];

    logic       push, pop;
    logic       flag_z, flag_n, flag_v, flag_lt, flag_ltu;
    logic [4:0] flags_new;

    assign sub_input1 = in_a;
    assign sub_input2 = in_b;

    assign in_ready  = (count_q != CntFull);
    assign out_valid = (count_q != CntEmpty);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_diff  = diff_q[rd_ptr_q];
    assign out_co    = co_q[rd_ptr_q];
    assign out_flags = flags_q[rd_ptr_q];

    // Compare flags from operand signs and the DSP difference; carry is deliberately unused.
    always_comb begin
        flag_z   = (sub_out == '0);
        flag_n   = sub_out[WIDTH-1];
        flag_v   = (in_a[WIDTH-1] ^ in_b[WIDTH-1]) & (sub_out[WIDTH-1] ^ in_a[WIDTH-1]);
        flag_lt  = flag_n ^ flag_v;
        flag_ltu = (in_a[WIDTH-1] ^ in_b[WIDTH-1]) ? in_b[WIDTH-1] : sub_out[WIDTH-1];
        flags_new = {flag_ltu, flag_lt, flag_v, flag_n, flag_z};
    end

    // Next occupancy: a push and a pop in the same cycle leave the count unchanged.
    always_comb begin
        count_d = count_q;
        unique case (count_q)
            CntEmpty: if (push) count_d = CntOne;
            CntOne: begin
                if (push && !pop)      count_d = CntFull;
                else if (pop && !push) count_d = CntEmpty;
            end
            CntFull:  if (pop) count_d = CntOne;
            default:  count_d = CntEmpty;
        endcase
    end

    // Occupancy and 1-bit wrapping read/write pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= CntEmpty;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        end
    end

    // Entry storage; written only on accept, so the head holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                diff_q[i]  <= '0;
                co_q[i]    <= 1'b0;
                flags_q[i] <= '0;
            end
        end else if (push) begin
            diff_q[wr_ptr_q]  <= sub_out;
            co_q[wr_ptr_q]    <= sub_co;
            flags_q[wr_ptr_q] <= flags_new;
        end
    end

`ifdef SUB_RESULT_CHECK_EN
    logic [WIDTH-1:0] fabric_diff;
    logic             mismatch_q;

    assign fabric_diff = in_a - in_b;
    assign mismatch    = mismatch_q;

    // Sticky DSP cross-check; cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else if (push && (fabric_diff != sub_out)) begin
            mismatch_q <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule
